// File: rtl/mole_pkg.sv
// ----------------------------------------------------------------------------
// mole_pkg
// Shared types and constants for the whack-a-mole button input stage.
//   deb_state_t        : per-channel debounce FSM states
//   CLK_HZ             : board clock frequency
//   DEB_CYCLES_DEFAULT : default debounce hold time (2 ms at 50 MHz)
//   N_MOLES            : number of mole buttons / LEDs on the board
//   lowest_set_idx()   : index of the lowest set bit of a vector (0 if none)
// ----------------------------------------------------------------------------
package mole_pkg;

    typedef enum logic [1:0] {
        REL  = 2'd0,
        PCHK = 2'd1,
        PRS  = 2'd2,
        RCHK = 2'd3
    } deb_state_t;

    localparam int CLK_HZ             = 50_000_000;
    localparam int DEB_CYCLES_DEFAULT = 100000;
    localparam int N_MOLES            = 9;

    // Scanning from the top down lets the lowest set bit win the last write.
    function automatic logic [3:0] lowest_set_idx(input logic [15:0] i_vec);
        logic [3:0] idx;
        idx = '0;
        for (int b = 15; b >= 0; b--) begin
            if (i_vec[b]) begin
                idx = 4'(b);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/mole_btn_debounce_ch.sv
// ----------------------------------------------------------------------------
// mole_btn_debounce_ch
// One button channel: 2-flop synchroniser followed by a 4-state debounce FSM
// with a hold counter. A new level is accepted only after the synchronised
// input has held it for DEB_CYCLES consecutive samples.
// Ports:
//   cin       : clock, rising edge
//   rst_n     : asynchronous active-low reset
//   i_btn     : polarity-normalised raw button (1 = pressed), asynchronous
//   o_level   : debounced pressed state
//   o_press   : one-cycle pulse when o_level goes 0->1
//   o_release : one-cycle pulse when o_level goes 1->0
// ----------------------------------------------------------------------------
module mole_btn_debounce_ch
    import mole_pkg::*;
#(
    parameter int DEB_CYCLES = DEB_CYCLES_DEFAULT,
    parameter int CNT_W      = 17
) (
    input  logic cin,
    input  logic rst_n,
    input  logic i_btn,
    output logic o_level,
    output logic o_press,
    output logic o_release
);

    // DEB_CYCLES must lie in 2 .. 2^CNT_W-1, so the counter never wraps.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic             r_syncMeta;
    logic             r_sync;
    deb_state_t       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_level;
    logic             r_press;
    logic             r_release;

    // Two-flop synchroniser; both flops clear to "not pressed".
    always_ff @(posedge cin or negedge rst_n) begin
        if (!rst_n) begin
            r_syncMeta <= 1'b0;
            r_sync     <= 1'b0;
        end else begin
            r_syncMeta <= i_btn;
            r_sync     <= r_syncMeta;
        end
    end

    // Debounce FSM. Entering a CHK state counts as the first sample, so the
    // counter starts at 1 and the level flips on sample number DEB_CYCLES.
    // A disagreeing sample in a CHK state drops straight back without a pulse.
    always_ff @(posedge cin or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= REL;
            r_cnt     <= '0;
            r_level   <= 1'b0;
            r_press   <= 1'b0;
            r_release <= 1'b0;
        end else begin
            r_press   <= 1'b0;
            r_release <= 1'b0;
            case (r_state)
                REL: begin
                    if (r_sync) begin
                        r_state <= PCHK;
                        r_cnt   <= CNT_ONE;
                    end
                end
                PCHK: begin
                    if (!r_sync) begin
                        r_state <= REL;
                        r_cnt   <= '0;
                    end else if (r_cnt == CNT_LAST) begin
                        r_state <= PRS;
                        r_cnt   <= '0;
                        r_level <= 1'b1;
                        r_press <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + CNT_ONE;
                    end
                end
                PRS: begin
                    if (!r_sync) begin
                        r_state <= RCHK;
                        r_cnt   <= CNT_ONE;
                    end
                end
                RCHK: begin
                    if (r_sync) begin
                        r_state <= PRS;
                        r_cnt   <= '0;
                    end else if (r_cnt == CNT_LAST) begin
                        r_state   <= REL;
                        r_cnt     <= '0;
                        r_level   <= 1'b0;
                        r_release <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + CNT_ONE;
                    end
                end
                default: begin
                    r_state <= REL;
                    r_cnt   <= '0;
                    r_level <= 1'b0;
                end
            endcase
        end
    end

    assign o_level   = r_level;
    assign o_press   = r_press;
    assign o_release = r_release;

endmodule

// File: rtl/mole_button_conditioner.sv
// ----------------------------------------------------------------------------
// mole_button_conditioner
// Input stage for the whack-a-mole game: normalises button polarity, debounces
// every button channel and produces press/release pulses plus a registered
// "hit" event for the game/score logic.
// Ports:
//   cin           : 50 MHz board clock, rising edge
//   rst_n         : asynchronous active-low reset
//   btn_raw       : raw asynchronous button lines
//   btn_level     : debounced pressed state, 1 = pressed
//   press_pulse   : one-cycle pulse per debounced press
//   release_pulse : one-cycle pulse per debounced release
//   hit_valid     : strobe, some press_pulse fired in the previous cycle
//   hit_idx       : lowest button index among those presses
//   multi_hit     : more than one press_pulse fired in that cycle
// ----------------------------------------------------------------------------
module mole_button_conditioner
    import mole_pkg::*;
#(
    parameter int N_BTN       = N_MOLES,
    parameter int DEB_CYCLES  = DEB_CYCLES_DEFAULT,
    parameter int CNT_W       = 17,
    parameter int ACTIVE_HIGH = 1
) (
    input  logic             cin,
    input  logic             rst_n,
    input  logic [N_BTN-1:0] btn_raw,
    output logic [N_BTN-1:0] btn_level,
    output logic [N_BTN-1:0] press_pulse,
    output logic [N_BTN-1:0] release_pulse,
    output logic             hit_valid,
    output logic [3:0]       hit_idx,
    output logic             multi_hit
);

    localparam logic [N_BTN-1:0] INV_MASK = (ACTIVE_HIGH != 0) ? '0 : '1;

    logic [N_BTN-1:0] w_btnNorm;
    logic [15:0]      w_pressWide;
    logic             w_multi;
    logic             r_hitValid;
    logic [3:0]       r_hitIdx;
    logic             r_multiHit;

    // Everything downstream sees 1 = pressed regardless of board wiring.
    assign w_btnNorm = btn_raw ^ INV_MASK;

    generate
        for (genvar g = 0; g < N_BTN; g++) begin : g_ch
            mole_btn_debounce_ch #(
                .DEB_CYCLES (DEB_CYCLES),
                .CNT_W      (CNT_W)
            ) u_ch (
                .cin       (cin),
                .rst_n     (rst_n),
                .i_btn     (w_btnNorm[g]),
                .o_level   (btn_level[g]),
                .o_press   (press_pulse[g]),
                .o_release (release_pulse[g])
            );
        end
    endgenerate

    assign w_pressWide = 16'(press_pulse);

    // Clearing the lowest set bit leaves something only if two or more were set.
    assign w_multi = |(press_pulse & (press_pulse - N_BTN'(1)));

    // Registered hit encoder; all fields read 0 in cycles with no press.
    always_ff @(posedge cin or negedge rst_n) begin
        if (!rst_n) begin
            r_hitValid <= 1'b0;
            r_hitIdx   <= '0;
            r_multiHit <= 1'b0;
        end else begin
            r_hitValid <= |press_pulse;
            r_hitIdx   <= lowest_set_idx(w_pressWide);
            r_multiHit <= w_multi;
        end
    end

    assign hit_valid = r_hitValid;
    assign hit_idx   = r_hitIdx;
    assign multi_hit = r_multiHit;

endmodule

// File: tb/tb_mole_button_conditioner.sv
// ----------------------------------------------------------------------------
// tb_mole_button_conditioner
// Bench for the button conditioner with DEB_CYCLES = 4. Instance A uses
// active-high buttons, instance B active-low buttons. A behavioural model
// derives the expected outputs from the debounce rule: a button's level flips
// once the last DEB synchronised samples all disagree with it.
// ----------------------------------------------------------------------------
module tb_mole_button_conditioner;

    localparam int DEB = 4;
    localparam int NB  = 9;

    logic          clk;
    logic          rst_n;
    logic [NB-1:0] rawA, rawB;
    logic [NB-1:0] levelA, pressA, relA, levelB, pressB, relB;
    logic          hitVA, multiA, hitVB, multiB;
    logic [3:0]    idxA, idxB;

    int checks = 0;
    int errors = 0;

    mole_button_conditioner #(
        .N_BTN(NB), .DEB_CYCLES(DEB), .CNT_W(17), .ACTIVE_HIGH(1)
    ) dutA (
        .cin(clk), .rst_n(rst_n), .btn_raw(rawA),
        .btn_level(levelA), .press_pulse(pressA), .release_pulse(relA),
        .hit_valid(hitVA), .hit_idx(idxA), .multi_hit(multiA)
    );

    mole_button_conditioner #(
        .N_BTN(NB), .DEB_CYCLES(DEB), .CNT_W(17), .ACTIVE_HIGH(0)
    ) dutB (
        .cin(clk), .rst_n(rst_n), .btn_raw(rawB),
        .btn_level(levelB), .press_pulse(pressB), .release_pulse(relB),
        .hit_valid(hitVB), .hit_idx(idxB), .multi_hit(multiB)
    );

    // Free-running clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ------------------------------------------------------------------------
    // Behavioural model, one slot per instance (0 = A, 1 = B).
    // ------------------------------------------------------------------------
    logic [NB-1:0] pipe   [2][2];
    logic [NB-1:0] win    [2][DEB];
    int            winFill[2];
    logic [NB-1:0] mLevel [2];
    logic [NB-1:0] mPress [2];
    logic [NB-1:0] mRel   [2];
    logic          mHitV  [2];
    logic [3:0]    mIdx   [2];
    logic          mMulti [2];

    task automatic modelReset();
        for (int m = 0; m < 2; m++) begin
            pipe[m][0] = '0;
            pipe[m][1] = '0;
            for (int k = 0; k < DEB; k++) win[m][k] = '0;
            winFill[m] = 0;
            mLevel[m]  = '0;
            mPress[m]  = '0;
            mRel[m]    = '0;
            mHitV[m]   = 1'b0;
            mIdx[m]    = '0;
            mMulti[m]  = 1'b0;
        end
    endtask

    task automatic modelStep(input int m, input logic [NB-1:0] norm);
        logic [NB-1:0] syncNow;
        logic [NB-1:0] flip;
        logic          allDiffer;
        int            ones;
        mHitV[m] = |mPress[m];
        mIdx[m]  = '0;
        ones     = 0;
        for (int b = NB - 1; b >= 0; b--) begin
            if (mPress[m][b]) begin
                mIdx[m] = 4'(b);
                ones++;
            end
        end
        mMulti[m] = (ones > 1);
        // Raw input reaches the debounce logic two edges after capture.
        syncNow    = pipe[m][0];
        pipe[m][0] = pipe[m][1];
        pipe[m][1] = norm;
        for (int k = DEB - 1; k > 0; k--) win[m][k] = win[m][k-1];
        win[m][0] = syncNow;
        if (winFill[m] < DEB) winFill[m]++;
        flip = '0;
        if (winFill[m] == DEB) begin
            for (int b = 0; b < NB; b++) begin
                allDiffer = 1'b1;
                for (int k = 0; k < DEB; k++) begin
                    if (win[m][k][b] == mLevel[m][b]) allDiffer = 1'b0;
                end
                flip[b] = allDiffer;
            end
        end
        mPress[m] = flip & ~mLevel[m];
        mRel[m]   = flip & mLevel[m];
        mLevel[m] = mLevel[m] ^ flip;
    endtask

    initial begin
        modelReset();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                modelReset();
            end else begin
                modelStep(0, rawA);
                modelStep(1, ~rawB);
            end
        end
    end

    // ------------------------------------------------------------------------
    // Checking helpers.
    // ------------------------------------------------------------------------
    task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Compare both instances against the model on every falling edge.
    initial begin
        forever begin
            @(negedge clk);
            checkOutput("A.btn_level",     16'(levelA), 16'(mLevel[0]));
            checkOutput("A.press_pulse",   16'(pressA), 16'(mPress[0]));
            checkOutput("A.release_pulse", 16'(relA),   16'(mRel[0]));
            checkOutput("A.hit_valid",     16'(hitVA),  16'(mHitV[0]));
            checkOutput("A.hit_idx",       16'(idxA),   16'(mIdx[0]));
            checkOutput("A.multi_hit",     16'(multiA), 16'(mMulti[0]));
            checkOutput("B.btn_level",     16'(levelB), 16'(mLevel[1]));
            checkOutput("B.press_pulse",   16'(pressB), 16'(mPress[1]));
            checkOutput("B.release_pulse", 16'(relB),   16'(mRel[1]));
            checkOutput("B.hit_valid",     16'(hitVB),  16'(mHitV[1]));
            checkOutput("B.hit_idx",       16'(idxB),   16'(mIdx[1]));
            checkOutput("B.multi_hit",     16'(multiB), 16'(mMulti[1]));
        end
    end

    // Let n rising edges pass, then settle on the following falling edge.
    task automatic waitEdges(input int n);
        repeat (n) @(posedge clk);
        @(negedge clk);
    endtask

    task automatic applyStimulus(input logic [NB-1:0] a, input logic [NB-1:0] b);
        rawA = a;
        rawB = b;
    endtask

    // ------------------------------------------------------------------------
    // Directed sequence with hand-computed literal expectations.
    // ------------------------------------------------------------------------
    initial begin
        int pulses;
        rst_n = 1'b1;
        applyStimulus(9'h000, 9'h1FF);
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("reset level", 16'(levelA), 16'h0000);
        checkOutput("reset hit",   16'(hitVA),  16'h0000);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        // Clean press of button 3.
        applyStimulus(9'h008, 9'h1FF);
        waitEdges(6);
        checkOutput("clean press_pulse", 16'(pressA), 16'h0008);
        checkOutput("clean btn_level",   16'(levelA), 16'h0008);
        waitEdges(1);
        checkOutput("clean hit_valid", 16'(hitVA),  16'h0001);
        checkOutput("clean hit_idx",   16'(idxA),   16'h0003);
        checkOutput("clean multi_hit", 16'(multiA), 16'h0000);
        checkOutput("clean pulse end", 16'(pressA), 16'h0000);
        waitEdges(1);
        checkOutput("clean hit end", 16'(hitVA), 16'h0000);

        // Bounce on button 0: three raw samples high, then low.
        applyStimulus(9'h009, 9'h1FF);
        repeat (3) @(posedge clk);
        @(negedge clk);
        applyStimulus(9'h008, 9'h1FF);
        pulses = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (pressA[0]) pulses++;
        end
        checkOutput("bounce no pulse", 16'(pulses),    16'h0000);
        checkOutput("bounce level",    16'(levelA[0]), 16'h0000);
        applyStimulus(9'h009, 9'h1FF);
        pulses = 0;
        for (int c = 0; c < 14; c++) begin
            @(negedge clk);
            if (pressA[0]) pulses++;
        end
        checkOutput("hold one pulse", 16'(pulses), 16'h0001);
        applyStimulus(9'h008, 9'h1FF);
        repeat (10) @(negedge clk);

        // Release of button 3.
        applyStimulus(9'h000, 9'h1FF);
        waitEdges(6);
        checkOutput("release pulse", 16'(relA),   16'h0008);
        checkOutput("release level", 16'(levelA), 16'h0000);
        waitEdges(1);
        checkOutput("release no hit", 16'(hitVA), 16'h0000);

        // Buttons 5 and 2 together.
        applyStimulus(9'h024, 9'h1FF);
        waitEdges(6);
        checkOutput("simul press_pulse", 16'(pressA), 16'h0024);
        waitEdges(1);
        checkOutput("simul hit_valid", 16'(hitVA),  16'h0001);
        checkOutput("simul hit_idx",   16'(idxA),   16'h0002);
        checkOutput("simul multi_hit", 16'(multiA), 16'h0001);
        waitEdges(2);

        // Reset in the middle of debouncing button 7.
        applyStimulus(9'h0A4, 9'h1FF);
        @(posedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("midreset level", 16'(levelA), 16'h0000);
        checkOutput("midreset press", 16'(pressA), 16'h0000);
        checkOutput("midreset hit",   16'(hitVA),  16'h0000);
        applyStimulus(9'h080, 9'h1FF);
        @(negedge clk);
        rst_n = 1'b1;
        waitEdges(6);
        checkOutput("post-reset press", 16'(pressA), 16'h0080);
        waitEdges(1);
        checkOutput("post-reset hit_valid", 16'(hitVA), 16'h0001);
        checkOutput("post-reset hit_idx",   16'(idxA),  16'h0007);

        // Active-low instance: pull button 8 low.
        applyStimulus(9'h080, 9'h0FF);
        waitEdges(6);
        checkOutput("polarity press_pulse", 16'(pressB), 16'h0100);
        waitEdges(1);
        checkOutput("polarity hit_valid", 16'(hitVB), 16'h0001);
        checkOutput("polarity hit_idx",   16'(idxB),  16'h0008);

        waitEdges(10);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
